ex_mem_reg: RTL and testbench

- EX/MEM pipeline register of the five-stage RISC-V core, directly downstream of the EX-stage write-back data mux.
- Captures the selected write-back data wD together with the store, register-write and PC bookkeeping from EX, and presents them to MEM.
- Supports stall (hold) and flush (bubble) from the hazard unit.
- Provides EX/MEM-stage forwarding-hit and load-use detection for the ID-stage operands rs1/rs2.

---
 rtl/ex_mem_reg_pkg.sv | 14 +
 rtl/pipe_field.sv | 28 ++
 rtl/ex_mem_reg.sv | 86 ++++++++
 tb/tb_ex_mem_reg.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_reg_pkg.sv
// rtl/ex_mem_reg_pkg.sv - shared widths and write-back select codes for the EX/MEM stage
package ex_mem_reg_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int REG_AW_DEF = 5;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_EXT  = 2'b01,
        WB_PC   = 2'b10,
        WB_DRAM = 2'b11
    } wb_sel_e;

endpackage

// File: rtl/pipe_field.sv
// rtl/pipe_field.sv - pipeline field register: async active-low reset, flush clears, stall holds
module pipe_field #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_stall,
    input  logic         i_flush,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    // flush outranks stall so a held bubble can still be squashed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_flush) begin
            r_q <= '0;
        end else if (!i_stall) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/ex_mem_reg.sv
// rtl/ex_mem_reg.sv - EX/MEM pipeline register with forwarding-hit and load-use detection
module ex_mem_reg
    import ex_mem_reg_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              ex_valid,
    input  logic [XLEN-1:0]   ex_pc,
    input  logic [XLEN-1:0]   ex_wD,
    input  logic [XLEN-1:0]   ex_aluc,
    input  logic [XLEN-1:0]   ex_rD2,
    input  logic [REG_AW-1:0] ex_wR,
    input  logic              ex_rf_we,
    input  logic [1:0]        ex_rf_wsel,
    input  logic              ex_dram_we,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    output logic              mem_valid,
    output logic [XLEN-1:0]   mem_pc,
    output logic [XLEN-1:0]   mem_wD,
    output logic [XLEN-1:0]   mem_aluc,
    output logic [XLEN-1:0]   mem_rD2,
    output logic [REG_AW-1:0] mem_wR,
    output logic              mem_rf_we,
    output logic [1:0]        mem_rf_wsel,
    output logic              mem_dram_we,
    output logic              fwd_rs1_hit,
    output logic              fwd_rs2_hit,
    output logic [XLEN-1:0]   fwd_data,
    output logic              load_use
);

    localparam int CTRL_W = 5 + REG_AW;
    localparam int DATA_W = 4 * XLEN;

    logic [CTRL_W-1:0] w_ctrl_d;
    logic [CTRL_W-1:0] w_ctrl_q;
    logic [DATA_W-1:0] w_data_d;
    logic [DATA_W-1:0] w_data_q;
    logic              w_wr_ok;
    logic              w_is_load;
    logic              w_rs1_match;
    logic              w_rs2_match;

    // write enables are masked by valid so a bubble entering MEM can never write
    assign w_ctrl_d = {ex_valid, ex_valid & ex_rf_we, ex_valid & ex_dram_we, ex_rf_wsel, ex_wR};
    assign w_data_d = {ex_pc, ex_wD, ex_aluc, ex_rD2};

    pipe_field #(.W(CTRL_W)) u_ctrl (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_stall (stall),
        .i_flush (flush),
        .i_d     (w_ctrl_d),
        .o_q     (w_ctrl_q)
    );

    pipe_field #(.W(DATA_W)) u_data (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_stall (stall),
        .i_flush (flush),
        .i_d     (w_data_d),
        .o_q     (w_data_q)
    );

    assign {mem_valid, mem_rf_we, mem_dram_we, mem_rf_wsel, mem_wR} = w_ctrl_q;
    assign {mem_pc, mem_wD, mem_aluc, mem_rD2}                      = w_data_q;

    // x0 is excluded here, so neither hits nor load_use can ever fire on it
    assign w_wr_ok     = mem_valid & mem_rf_we & (mem_wR != '0);
    assign w_is_load   = (mem_rf_wsel == WB_DRAM);
    assign w_rs1_match = (mem_wR == id_rs1);
    assign w_rs2_match = (mem_wR == id_rs2);

    assign fwd_rs1_hit = w_wr_ok & w_rs1_match & ~w_is_load;
    assign fwd_rs2_hit = w_wr_ok & w_rs2_match & ~w_is_load;
    assign fwd_data    = mem_wD;
    assign load_use    = w_wr_ok & w_is_load & (w_rs1_match | w_rs2_match);

endmodule

// File: tb/tb_ex_mem_reg.sv
// tb/tb_ex_mem_reg.sv - self-checking bench for ex_mem_reg against a field-level reference model
module tb_ex_mem_reg;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        ex_valid = 1'b0;
    logic [31:0] ex_pc = '0;
    logic [31:0] ex_wD = '0;
    logic [31:0] ex_aluc = '0;
    logic [31:0] ex_rD2 = '0;
    logic [4:0]  ex_wR = '0;
    logic        ex_rf_we = 1'b0;
    logic [1:0]  ex_rf_wsel = '0;
    logic        ex_dram_we = 1'b0;
    logic [4:0]  id_rs1 = '0;
    logic [4:0]  id_rs2 = '0;

    logic        mem_valid;
    logic [31:0] mem_pc, mem_wD, mem_aluc, mem_rD2;
    logic [4:0]  mem_wR;
    logic        mem_rf_we;
    logic [1:0]  mem_rf_wsel;
    logic        mem_dram_we;
    logic        fwd_rs1_hit, fwd_rs2_hit;
    logic [31:0] fwd_data;
    logic        load_use;

    ex_mem_reg #(.XLEN(32), .REG_AW(5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .flush       (flush),
        .ex_valid    (ex_valid),
        .ex_pc       (ex_pc),
        .ex_wD       (ex_wD),
        .ex_aluc     (ex_aluc),
        .ex_rD2      (ex_rD2),
        .ex_wR       (ex_wR),
        .ex_rf_we    (ex_rf_we),
        .ex_rf_wsel  (ex_rf_wsel),
        .ex_dram_we  (ex_dram_we),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .mem_valid   (mem_valid),
        .mem_pc      (mem_pc),
        .mem_wD      (mem_wD),
        .mem_aluc    (mem_aluc),
        .mem_rD2     (mem_rD2),
        .mem_wR      (mem_wR),
        .mem_rf_we   (mem_rf_we),
        .mem_rf_wsel (mem_rf_wsel),
        .mem_dram_we (mem_dram_we),
        .fwd_rs1_hit (fwd_rs1_hit),
        .fwd_rs2_hit (fwd_rs2_hit),
        .fwd_data    (fwd_data),
        .load_use    (load_use)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // reference: the MEM-stage instruction as a plain record
    typedef struct {
        bit        valid;
        bit [31:0] pc, wD, aluc, rD2;
        bit [4:0]  wR;
        bit        rf_we, dram_we;
        bit [1:0]  wsel;
    } stage_t;

    stage_t m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m = '{default: 0};
    endtask

    task automatic model_edge();
        if (!rst_n || flush) begin
            model_clear();
        end else if (!stall) begin
            m.valid   = ex_valid;
            m.pc      = ex_pc;
            m.wD      = ex_wD;
            m.aluc    = ex_aluc;
            m.rD2     = ex_rD2;
            m.wR      = ex_wR;
            m.wsel    = ex_rf_wsel;
            m.rf_we   = ex_valid ? ex_rf_we : 1'b0;
            m.dram_we = ex_valid ? ex_dram_we : 1'b0;
        end
    endtask

    task automatic check_all(input string tag);
        bit writes, from_dram, h1, h2, lu;
        writes    = m.valid && m.rf_we && (m.wR != 0);
        from_dram = (m.wsel == 2'd3);
        h1 = writes && !from_dram && (m.wR == id_rs1);
        h2 = writes && !from_dram && (m.wR == id_rs2);
        lu = writes && from_dram && ((m.wR == id_rs1) || (m.wR == id_rs2));
        check({tag, ".valid"},   mem_valid,   m.valid);
        check({tag, ".pc"},      mem_pc,      m.pc);
        check({tag, ".wD"},      mem_wD,      m.wD);
        check({tag, ".aluc"},    mem_aluc,    m.aluc);
        check({tag, ".rD2"},     mem_rD2,     m.rD2);
        check({tag, ".wR"},      mem_wR,      m.wR);
        check({tag, ".rf_we"},   mem_rf_we,   m.rf_we);
        check({tag, ".wsel"},    mem_rf_wsel, m.wsel);
        check({tag, ".dram_we"}, mem_dram_we, m.dram_we);
        check({tag, ".hit1"},    fwd_rs1_hit, h1);
        check({tag, ".hit2"},    fwd_rs2_hit, h2);
        check({tag, ".fwd"},     fwd_data,    m.wD);
        check({tag, ".lu"},      load_use,    lu);
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_ex(input bit v, input bit [31:0] pc, input bit [31:0] wd,
                          input bit [4:0] wr, input bit we, input bit [1:0] ws, input bit dwe);
        ex_valid = v; ex_pc = pc; ex_wD = wd; ex_wR = wr;
        ex_rf_we = we; ex_rf_wsel = ws; ex_dram_we = dwe;
    endtask

    initial begin
        model_clear();
        set_ex(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h1F, 1, 2'b11, 1);
        ex_aluc = 32'hFFFF_FFFF; ex_rD2 = 32'hFFFF_FFFF;
        @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;
        #1 check_all("reset_release");
        tick();
        check_all("load_ones");
        // async reset mid-cycle with no clock edge in between
        #2 rst_n = 1'b0;
        #1 model_clear();
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        #1 check_all("post_rst");
        @(negedge clk);

        set_ex(1, 32'h0, 32'h1234_5678, 5'd5, 1, 2'b00, 0);
        ex_aluc = 0; ex_rD2 = 0; id_rs1 = 5; id_rs2 = 0;
        tick();
        check_all("normal");
        check("normal.wD_abs", mem_wD, 32'h1234_5678);
        check("normal.hit_abs", fwd_rs1_hit, 1);

        ex_pc = 32'h100;
        tick();
        ex_pc = 32'h200; stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall.pc_abs", mem_pc, 32'h100);
        end
        check_all("stall");
        flush = 1;
        tick();
        check_all("stall_flush");
        stall = 0; flush = 0;

        set_ex(1, 32'h300, 32'hDEAD_0000, 5'd7, 1, 2'b11, 0);
        id_rs1 = 1; id_rs2 = 7;
        tick();
        check_all("load_use");
        check("load_use.abs", load_use, 1);
        id_rs2 = 8;
        #1 check_all("load_use_miss");

        set_ex(1, 32'h304, 32'h55, 5'd0, 1, 2'b00, 0);
        id_rs1 = 0; id_rs2 = 0;
        tick();
        check_all("x0");
        set_ex(0, 32'h308, 32'h66, 5'd3, 1, 2'b00, 1);
        id_rs1 = 3;
        tick();
        check_all("bubble");

        set_ex(1, 32'h30C, 32'h0, 5'd9, 0, 2'b00, 1);
        ex_aluc = 32'h40; ex_rD2 = 32'hCAFE_BABE; id_rs1 = 9; id_rs2 = 9;
        tick();
        check_all("store");
        check("store.rD2_abs", mem_rD2, 32'hCAFE_BABE);

        for (int i = 0; i < 400; i++) begin
            set_ex(1'($urandom), $urandom, $urandom, 5'($urandom_range(0, 3)),
                   1'($urandom), 2'($urandom), 1'($urandom));
            ex_aluc = $urandom; ex_rD2 = $urandom;
            id_rs1 = 5'($urandom_range(0, 3));
            id_rs2 = 5'($urandom_range(0, 3));
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 7) == 0);
            tick();
            check_all("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
